// File: rtl/memory_control.sv
// Arbitrates one RAM port between instruction and data requesters, alternating on contention.
// Optional completion counters are enabled by defining MEMCTRL_STATS_EN.
module memory_control #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    output logic             iwait,
    output logic [31:0]      iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] dcount
);
    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t state_reg, state_next;
    logic   lastd_reg;
    logic   d_req;
    logic   d_done, i_done;

    assign d_req = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= IDLE;
            lastd_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (d_done)
                lastd_reg <= 1'b1;
            else if (i_done)
                lastd_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        d_done     = 1'b0;
        i_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Data goes first unless it was served last and instruction is waiting
                if (d_req && !(lastd_reg && iREN))
                    state_next = DSERV;
                else if (iREN)
                    state_next = ISERV;
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    d_done     = 1'b1;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR || !d_req) begin
                    state_next = IDLE;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramstate == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    i_done     = 1'b1;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR || !iREN) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MEMCTRL_STATS_EN
    logic [CNT_W-1:0] icount_reg, dcount_reg;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount_reg <= '0;
            dcount_reg <= '0;
        end else begin
            if (i_done && icount_reg != '1)
                icount_reg <= icount_reg + 1'b1;
            if (d_done && dcount_reg != '1)
                dcount_reg <= dcount_reg + 1'b1;
        end
    end

    assign icount = icount_reg;
    assign dcount = dcount_reg;
`else
    assign icount = '0;
    assign dcount = '0;
`endif
endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: directed scenarios plus random traffic
// compared against a transaction-level arbitration model.
module tb_memory_control;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MEMCTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic             iREN = 1'b0;
    logic [31:0]      iaddr = '0;
    logic             iwait;
    logic [31:0]      iload;
    logic             dREN = 1'b0;
    logic             dWEN = 1'b0;
    logic [31:0]      daddr = '0;
    logic [31:0]      dstore = '0;
    logic             dwait;
    logic [31:0]      dload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload = '0;
    logic [1:0]       ramstate = 2'd0;
    logic [CNT_W-1:0] icount;
    logic [CNT_W-1:0] dcount;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the RAM (0 none, 1 data, 2 instruction), who was served last, completions
    int m_owner = 0;
    bit m_lastd = 1'b0;
    int m_icnt  = 0;
    int m_dcnt  = 0;

    memory_control #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .icount(icount), .dcount(dcount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [CNT_W-1:0] exp_cnt(input int m);
        return STATS ? m[CNT_W-1:0] : '0;
    endfunction

    // Advance one clock and apply the arbitration rules to the model
    task automatic tick();
        @(posedge CLK);
        if (!nRST) begin
            m_owner = 0; m_lastd = 0; m_icnt = 0; m_dcnt = 0;
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && !(m_lastd && iREN)) m_owner = 1;
            else if (iREN) m_owner = 2;
        end else if (ramstate == 2'd2) begin
            if (m_owner == 1) begin
                m_lastd = 1; m_dcnt = (m_dcnt < CNT_MAX) ? m_dcnt + 1 : CNT_MAX;
            end else begin
                m_lastd = 0; m_icnt = (m_icnt < CNT_MAX) ? m_icnt + 1 : CNT_MAX;
            end
            m_owner = 0;
        end else if (ramstate == 2'd3) begin
            m_owner = 0;
        end else if (m_owner == 1 && !(dREN || dWEN)) begin
            m_owner = 0;
        end else if (m_owner == 2 && !iREN) begin
            m_owner = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
        nRST = 0;
        tick();
        nRST = 1;
    endtask

    task automatic test_reset();
        iREN = 1; dREN = 1; ramstate = 2'd1;
        tick();
        tick();
        do_reset();
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_fail++; $display("FAIL reset_ctrl got %b expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        n_checks++;
        if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus got addr=%h store=%h expected 0/0", ramaddr, ramstore);
        end
        n_checks++;
        if (icount !== '0 || dcount !== '0) begin
            n_fail++; $display("FAIL reset_cnt got i=%h d=%h expected 0/0", icount, dcount);
        end
        $display("test_reset: done");
    endtask

    task automatic test_dread();
        int ren_cycles = 0;
        do_reset();
        dREN = 1; daddr = 32'h100; ramstate = 2'd0;
        #1;
        if (ramREN) ren_cycles++;
        tick();
        for (int c = 0; c < 3; c++) begin
            ramstate = (c < 2) ? 2'd1 : 2'd2;
            ramload = 32'hDEADBEEF;
            #1;
            if (ramREN) ren_cycles++;
            n_checks++;
            if (dwait !== (c < 2) || ramaddr !== 32'h100) begin
                n_fail++; $display("FAIL dread_c%0d got dwait=%b addr=%h expected %b/00000100", c, dwait, ramaddr, (c < 2));
            end
            tick();
        end
        n_checks++;
        if (dload !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dread_load got %h expected deadbeef", dload);
        end
        dREN = 0; ramstate = 2'd0;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1 || ren_cycles != 3) begin
            n_fail++; $display("FAIL dread_idle got ren=%b dwait=%b rencycles=%0d expected 0/1/3", ramREN, dwait, ren_cycles);
        end
        n_checks++;
        if (dcount !== exp_cnt(1)) begin
            n_fail++; $display("FAIL dread_cnt got %h expected %h", dcount, exp_cnt(1));
        end
        $display("test_dread: done, ramREN cycles=%0d", ren_cycles);
    endtask

    task automatic test_alternation();
        byte seq[$];
        string exp_seq = "DIDI";
        do_reset();
        iREN = 1; dWEN = 1; ramstate = 2'd2; iaddr = 32'h40; daddr = 32'h80;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ramWEN) seq.push_back("D");
            else if (ramREN) seq.push_back("I");
            tick();
        end
        iREN = 0; dWEN = 0; ramstate = 2'd0;
        n_checks++;
        if (seq.size() != 4) begin
            n_fail++; $display("FAIL alt_len got %0d expected 4", seq.size());
        end
        for (int k = 0; k < 4 && k < seq.size(); k++) begin
            n_checks++;
            if (seq[k] != exp_seq[k]) begin
                n_fail++; $display("FAIL alt_order[%0d] got %c expected %c", k, seq[k], exp_seq[k]);
            end
        end
        tick();
        $display("test_alternation: %0d transactions observed", seq.size());
    endtask

    task automatic test_write_wins();
        do_reset();
        dREN = 1; dWEN = 1; dstore = 32'h5A5A5A5A; daddr = 32'h200; ramstate = 2'd1;
        tick();
        #1;
        n_checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h5A5A5A5A) begin
            n_fail++; $display("FAIL write_wins got wen=%b ren=%b store=%h expected 1/0/5a5a5a5a", ramWEN, ramREN, ramstore);
        end
        ramstate = 2'd2;
        tick();
        dREN = 0; dWEN = 0; ramstate = 2'd0;
        $display("test_write_wins: done");
    endtask

    task automatic test_error();
        do_reset();
        iREN = 1; iaddr = $urandom; ramstate = 2'd3;
        tick();
        #1;
        n_checks++;
        if (ramREN !== 1'b1 || iwait !== 1'b1) begin
            n_fail++; $display("FAIL err_serv got ren=%b iwait=%b expected 1/1", ramREN, iwait);
        end
        tick();
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1 || icount !== '0) begin
            n_fail++; $display("FAIL err_idle got ren=%b iwait=%b icount=%h expected 0/1/0", ramREN, iwait, icount);
        end
        tick();
        #1;
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== iaddr) begin
            n_fail++; $display("FAIL err_retry got ren=%b addr=%h expected 1/%h", ramREN, ramaddr, iaddr);
        end
        iREN = 0; ramstate = 2'd0;
        tick();
        $display("test_error: done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        dREN = 1; daddr = 32'h300; ramstate = 2'd1;
        tick();
        #1;
        n_checks++;
        if (ramREN !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy got ren=%b expected 1", ramREN);
        end
        nRST = 0;
        tick();
        nRST = 1; dREN = 0; ramstate = 2'd0;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1 || dcount !== '0) begin
            n_fail++; $display("FAIL rstmid_after got ren=%b dwait=%b dcount=%h expected 0/1/0", ramREN, dwait, dcount);
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_saturation();
        do_reset();
        dREN = 1; ramstate = 2'd2;
        repeat (34) tick();
        dREN = 0; ramstate = 2'd0;
        #1;
        n_checks++;
        if (dcount !== (STATS ? 4'hF : 4'h0) || icount !== '0) begin
            n_fail++; $display("FAIL sat_dcount got d=%h i=%h expected %h/0", dcount, icount, (STATS ? 4'hF : 4'h0));
        end
        $display("test_saturation: dcount=%h after 17 completions", dcount);
    endtask

    task automatic test_random();
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        int errs_before = n_fail;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            iREN = ($urandom_range(0, 3) != 0);
            dREN = ($urandom_range(0, 2) == 0);
            dWEN = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            nRST = ($urandom_range(0, 49) != 0);
            #1;
            e_ren   = (m_owner == 2) || (m_owner == 1 && dREN && !dWEN);
            e_wen   = (m_owner == 1) && dWEN;
            e_addr  = (m_owner == 1) ? daddr : (m_owner == 2) ? iaddr : 32'h0;
            e_store = (m_owner == 1) ? dstore : 32'h0;
            e_iw    = !(m_owner == 2 && ramstate == 2'd2);
            e_dw    = !(m_owner == 1 && ramstate == 2'd2);
            n_checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== {e_ren, e_wen, e_iw, e_dw}) begin
                n_fail++; $display("FAIL rnd_ctrl c%0d got %b expected %b", c, {ramREN, ramWEN, iwait, dwait}, {e_ren, e_wen, e_iw, e_dw});
            end
            n_checks++;
            if (ramaddr !== e_addr || ramstore !== e_store) begin
                n_fail++; $display("FAIL rnd_bus c%0d got %h/%h expected %h/%h", c, ramaddr, ramstore, e_addr, e_store);
            end
            n_checks++;
            if (iload !== ramload || dload !== ramload) begin
                n_fail++; $display("FAIL rnd_load c%0d got %h/%h expected %h", c, iload, dload, ramload);
            end
            n_checks++;
            if (icount !== exp_cnt(m_icnt) || dcount !== exp_cnt(m_dcnt)) begin
                n_fail++; $display("FAIL rnd_cnt c%0d got %h/%h expected %h/%h", c, icount, dcount, exp_cnt(m_icnt), exp_cnt(m_dcnt));
            end
            tick();
        end
        nRST = 1;
        $display("test_random: 400 cycles, %0d new failures", n_fail - errs_before);
    endtask

    initial begin
        test_reset();
        test_dread();
        test_alternation();
        test_write_wins();
        test_error();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
